axi_default_slave: RTL and testbench

AXI slave that the interconnect routes any read or write to when the address matches no mapped slave. It completes every transaction legally so the issuing master never hangs. Read bursts return the programmed fill data with an error response, and beat count and RLAST follow ARLEN. Write bursts are accepted and discarded up to WLAST, then one error write response is returned. It connects as an extra slave port (S_DEF) beside IM and DM, using the widths from `AXI_define.svh`.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/default_slave_wr.sv | 66 ++++++
 rtl/axi_default_slave.sv | 117 +++++++++++
 tb/tb_axi_default_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the default slave: bus widths (mirroring AXI_define.svh),
// response codes and channel FSM state encodings.
package axi_pkg;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;
endpackage

// File: rtl/default_slave_wr.sv
// Write side of the default slave: accepts an AW, swallows W beats up to WLAST,
// then returns a single error response carrying the latched AWID.
module default_slave_wr
    import axi_pkg::*;
#(
    parameter logic [1:0] ERR_RESP = RESP_DECERR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_IDS_BITS-1:0] AWID,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [AXI_IDS_BITS-1:0] BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY
);
    wr_state_e               wr_state, wr_next;
    logic [AXI_IDS_BITS-1:0] wid_q;
    logic                    run_q;

    // run_q keeps AWREADY low while reset is held; it rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wid_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            wr_state <= wr_next;
            if (AWVALID && AWREADY)
                wid_q <= AWID;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (AWVALID && AWREADY)          wr_next = W_DATA;
            W_DATA:  if (WVALID && WREADY && WLAST)   wr_next = W_RESP;
            W_RESP:  if (BREADY)                      wr_next = W_IDLE;
            default:                                  wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BID     = '0;
        BRESP   = RESP_OKAY;
        case (wr_state)
            W_IDLE: AWREADY = run_q;
            W_DATA: WREADY  = 1'b1;
            W_RESP: begin
                BVALID = 1'b1;
                BID    = wid_q;
                BRESP  = ERR_RESP;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/axi_default_slave.sv
// Catch-all AXI slave for unmapped addresses: every read burst returns fill data with an
// error response, every write burst is dropped and answered with one error response.
module axi_default_slave
    import axi_pkg::*;
#(
    parameter logic [AXI_DATA_BITS-1:0] FILL_DATA = '0,
    parameter logic [1:0]               ERR_RESP  = RESP_DECERR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDS_BITS-1:0]  ARID,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE,
    input  logic [1:0]               ARBURST,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [AXI_IDS_BITS-1:0]  RID,
    output logic [AXI_DATA_BITS-1:0] RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    input  logic [AXI_IDS_BITS-1:0]  AWID,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN,
    input  logic [AXI_SIZE_BITS-1:0] AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [AXI_DATA_BITS-1:0] WDATA,
    input  logic [AXI_STRB_BITS-1:0] WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [AXI_IDS_BITS-1:0]  BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY
);
    rd_state_e               rd_state, rd_next;
    logic [AXI_IDS_BITS-1:0] rid_q;
    logic [AXI_LEN_BITS-1:0] rlen_q;
    logic [AXI_LEN_BITS-1:0] rcnt;
    logic                    run_q;

    // Address/size/burst fields and write payload carry no meaning for this slave.
    logic unused_fields;
    assign unused_fields = ^{ARADDR, ARSIZE, ARBURST, AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB};

    // rcnt never wraps: the last beat of a 16-beat burst is taken at rcnt == 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rid_q    <= '0;
            rlen_q   <= '0;
            rcnt     <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            rd_state <= rd_next;
            if (ARVALID && ARREADY) begin
                rid_q  <= ARID;
                rlen_q <= ARLEN;
                rcnt   <= '0;
            end else if (RVALID && RREADY && !RLAST) begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ARVALID && ARREADY)        rd_next = R_DATA;
            R_DATA:  if (RVALID && RREADY && RLAST) rd_next = R_IDLE;
            default:                                rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = RESP_OKAY;
        RLAST   = 1'b0;
        case (rd_state)
            R_IDLE: ARREADY = run_q;
            R_DATA: begin
                RVALID = 1'b1;
                RID    = rid_q;
                RDATA  = FILL_DATA;
                RRESP  = ERR_RESP;
                RLAST  = (rcnt == rlen_q);
            end
            default: ;
        endcase
    end

    default_slave_wr #(
        .ERR_RESP (ERR_RESP)
    ) u_wr (
        .clk     (clk),
        .rst     (rst),
        .AWID    (AWID),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY)
    );
endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: directed scenarios plus randomized read/write bursts,
// checked against transaction-level expectations (beat counts, IDs, responses, latency).
module tb_axi_default_slave;
    localparam logic [31:0] FILL = 32'hDEAD_BEEF;
    localparam logic [1:0]  ERR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [7:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_rbeats = 0, obs_rbeats = 0;
    int exp_b = 0, obs_b = 0;

    always #5 clk = ~clk;

    axi_default_slave #(.FILL_DATA(FILL), .ERR_RESP(ERR)) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: RREADY held high, 1: RREADY toggles 1/0, 2: RREADY random
    task automatic do_read(input logic [7:0] id, input logic [3:0] len, input int mode,
                           output int wait_cyc);
        int beat = 0;
        int cyc = 0;
        int nbeats;
        logic rr;
        nbeats = int'(len) + 1;
        ARID = id; ARLEN = len; ARADDR = $urandom; ARSIZE = 3'($urandom); ARBURST = 2'($urandom);
        ARVALID = 1'b1;
        wait_cyc = 0;
        while (!ARREADY && wait_cyc < 50) begin
            @(posedge clk); #1; wait_cyc++;
        end
        if (!ARREADY) chk("ar_timeout", 32'(wait_cyc), 0);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        exp_rbeats += nbeats;
        while (beat < nbeats && cyc < 200) begin
            chk("rvalid", 32'(RVALID), 1);
            chk("rid", 32'(RID), 32'(id));
            chk("arready_busy", 32'(ARREADY), 0);
            if (mode == 0)      rr = 1'b1;
            else if (mode == 1) rr = ((cyc % 2) == 0);
            else                rr = 1'($urandom_range(0, 1));
            RREADY = rr;
            chk("rlast", 32'(RLAST), 32'(beat == nbeats - 1));
            if (rr) begin
                chk("rdata", RDATA, FILL);
                chk("rresp", 32'(RRESP), 32'(ERR));
                beat++;
                obs_rbeats++;
            end
            @(posedge clk); #1; cyc++;
        end
        RREADY = 1'b0;
        if (beat < nbeats) chk("r_timeout", 32'(beat), 32'(nbeats));
        chk("r_done_rvalid", 32'(RVALID), 0);
        chk("r_done_arready", 32'(ARREADY), 1);
    endtask

    task automatic do_write(input logic [7:0] id, input int nbeats, input bit early,
                            input int bdly, input bit gaps, output int wait_cyc);
        int sent = 0;
        int cyc = 0;
        if (early) begin
            WVALID = 1'b1; WLAST = (nbeats == 1); WDATA = $urandom; WSTRB = 4'($urandom);
            repeat (2) begin
                chk("early_wready", 32'(WREADY), 0);
                @(posedge clk); #1;
            end
        end
        AWID = id; AWLEN = 4'(nbeats - 1); AWADDR = $urandom; AWSIZE = 3'($urandom);
        AWBURST = 2'($urandom);
        AWVALID = 1'b1;
        wait_cyc = 0;
        chk("wready_pre_aw", 32'(WREADY), 0);
        while (!AWREADY && wait_cyc < 50) begin
            @(posedge clk); #1; wait_cyc++;
            chk("wready_pre_aw", 32'(WREADY), 0);
        end
        if (!AWREADY) chk("aw_timeout", 32'(wait_cyc), 0);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        chk("wready_after_aw", 32'(WREADY), 1);
        exp_b++;
        while (sent < nbeats && cyc < 200) begin
            chk("bvalid_early", 32'(BVALID), 0);
            chk("wready", 32'(WREADY), 1);
            if (gaps && cyc > 0) WVALID = 1'($urandom_range(0, 1));
            else                 WVALID = 1'b1;
            WLAST = (sent == nbeats - 1);
            WDATA = $urandom;
            if (WVALID) sent++;
            @(posedge clk); #1; cyc++;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (sent < nbeats) chk("w_timeout", 32'(sent), 32'(nbeats));
        chk("bvalid", 32'(BVALID), 1);
        chk("bid", 32'(BID), 32'(id));
        chk("bresp", 32'(BRESP), 32'(ERR));
        chk("wready_resp", 32'(WREADY), 0);
        chk("awready_resp", 32'(AWREADY), 0);
        repeat (bdly) begin
            @(posedge clk); #1;
            chk("bvalid_hold", 32'(BVALID), 1);
            chk("bid_hold", 32'(BID), 32'(id));
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
        obs_b++;
        chk("b_done", 32'(BVALID), 0);
        chk("awready_back", 32'(AWREADY), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw, ww;
        #12;
        chk("rst_arready", 32'(ARREADY), 0);
        chk("rst_awready", 32'(AWREADY), 0);
        chk("rst_wready",  32'(WREADY), 0);
        chk("rst_rvalid",  32'(RVALID), 0);
        chk("rst_rlast",   32'(RLAST), 0);
        chk("rst_bvalid",  32'(BVALID), 0);
        chk("rst_rid",     32'(RID), 0);
        chk("rst_bid",     32'(BID), 0);
        chk("rst_rdata",   RDATA, 0);
        chk("rst_rresp",   32'(RRESP), 0);
        chk("rst_bresp",   32'(BRESP), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_arready", 32'(ARREADY), 1);
        chk("post_rst_awready", 32'(AWREADY), 1);

        // single read, max burst with back-pressure
        do_read(8'h12, 4'h0, 0, rw);
        do_read(8'h5A, 4'hF, 1, rw);
        // write burst with BREADY stalled, then early W
        do_write(8'h21, 4, 1'b0, 3, 1'b0, ww);
        do_write(8'h33, 3, 1'b1, 1, 1'b0, ww);

        // concurrent AR and AW in the same cycle
        fork
            do_read(8'h44, 4'h3, 0, rw);
            do_write(8'h55, 2, 1'b0, 0, 1'b0, ww);
        join
        chk("concurrent_ar_wait", 32'(rw), 0);
        chk("concurrent_aw_wait", 32'(ww), 0);

        // reset during the third beat of an 8-beat burst
        ARID = 8'h77; ARLEN = 4'h7; ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_rvalid", 32'(RVALID), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rvalid",  32'(RVALID), 0);
        chk("rst_async_arready", 32'(ARREADY), 0);
        chk("rst_async_rid",     32'(RID), 0);
        RREADY = 1'b0;
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_arready", 32'(ARREADY), 1);
        chk("rel_awready", 32'(AWREADY), 1);
        chk("rel_rvalid",  32'(RVALID), 0);

        // randomized traffic
        for (int i = 0; i < 24; i++) begin
            int kind;
            logic [7:0] rid_r, wid_r;
            logic [3:0] len_r;
            int nb, dly;
            bit early_r;
            kind = $urandom_range(0, 2);
            rid_r = 8'($urandom); wid_r = 8'($urandom); len_r = 4'($urandom);
            nb = $urandom_range(1, 8); dly = $urandom_range(0, 3);
            early_r = 1'($urandom_range(0, 1));
            if (kind == 0) do_read(rid_r, len_r, 2, rw);
            else if (kind == 1) do_write(wid_r, nb, early_r, dly, 1'b1, ww);
            else begin
                fork
                    do_read(rid_r, len_r, 2, rw);
                    do_write(wid_r, nb, 1'b0, dly, 1'b1, ww);
                join
                chk("rand_ar_wait", 32'(rw), 0);
                chk("rand_aw_wait", 32'(ww), 0);
            end
        end

        chk("total_rbeats", 32'(obs_rbeats), 32'(exp_rbeats));
        chk("total_bresp",  32'(obs_b), 32'(exp_b));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
